// File: rtl/wddr_rst_seq_pkg.sv
// Shared types and default timing for the LPDDR PHY reset sequencer.
// State encoding plus default per-state durations in refclk cycles.
package wddr_rst_seq_pkg;

  typedef enum logic [2:0] {
    S_PRE,
    S_PRST,
    S_RST,
    S_GATE,
    S_SETTLE,
    S_DONE
  } state_t;

  localparam int DEF_CNT_W      = 8;
  localparam int DEF_PRE_CYC    = 2;
  localparam int DEF_PRST_CYC   = 5;
  localparam int DEF_RST_CYC    = 5;
  localparam int DEF_CLKEN_CYC  = 5;
  localparam int DEF_SETTLE_CYC = 10;

endpackage

// File: rtl/wddr_rst_seq.sv
// Counter-timed POR / soft-reset sequencer for the LPDDR PHY.
// Ports: i_refclk, i_rst_n, i_sw_rst_req/o_sw_rst_ack, o_prst_n, o_rst,
//        o_jtag_trst_n, o_clk_en, o_ready, o_busy (all registered).
module wddr_rst_seq
  import wddr_rst_seq_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int PRE_CYC    = DEF_PRE_CYC,
  parameter int PRST_CYC   = DEF_PRST_CYC,
  parameter int RST_CYC    = DEF_RST_CYC,
  parameter int CLKEN_CYC  = DEF_CLKEN_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic i_refclk,
  input  logic i_rst_n,
  input  logic i_sw_rst_req,
  output logic o_sw_rst_ack,
  output logic o_prst_n,
  output logic o_rst,
  output logic o_jtag_trst_n,
  output logic o_clk_en,
  output logic o_ready,
  output logic o_busy
);

  localparam int CMAX = 2 ** CNT_W;

  if (PRE_CYC < 1 || PRST_CYC < 1 || RST_CYC < 1 ||
      CLKEN_CYC < 1 || SETTLE_CYC < 1 ||
      PRE_CYC > CMAX || PRST_CYC > CMAX || RST_CYC > CMAX ||
      CLKEN_CYC > CMAX || SETTLE_CYC > CMAX) begin : g_param_err
    $error("wddr_rst_seq: durations must be >= 1 and fit CNT_W");
  end

  localparam logic [CNT_W-1:0] L_PRE    = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] L_PRST   = CNT_W'(PRST_CYC - 1);
  localparam logic [CNT_W-1:0] L_RST    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] L_GATE   = CNT_W'(CLKEN_CYC - 1);
  localparam logic [CNT_W-1:0] L_SETTLE = CNT_W'(SETTLE_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Set while a software-initiated run still owes an ack.
  logic             sw_q, sw_d;
  logic             ack_d;
  logic             in_rst;

  always_ff @(posedge i_refclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_PRE;
      cnt_q   <= L_PRE;
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sw_d    = sw_q;
    ack_d   = o_sw_rst_ack;
    if (state_q == S_DONE) begin
      if (i_sw_rst_req && !o_sw_rst_ack) begin
        state_d = S_PRST;
        cnt_d   = L_PRST;
        sw_d    = 1'b1;
      end else begin
        ack_d = o_sw_rst_ack & i_sw_rst_req;
      end
    end else begin
      // Dropping the request mid-run forfeits the ack.
      if (!i_sw_rst_req) sw_d = 1'b0;
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        unique case (state_q)
          S_PRE: begin
            state_d = S_PRST;
            cnt_d   = L_PRST;
          end
          S_PRST: begin
            state_d = S_RST;
            cnt_d   = L_RST;
          end
          S_RST: begin
            state_d = S_GATE;
            cnt_d   = L_GATE;
          end
          S_GATE: begin
            state_d = S_SETTLE;
            cnt_d   = L_SETTLE;
          end
          S_SETTLE: begin
            state_d = S_DONE;
            cnt_d   = '0;
            ack_d   = sw_q & i_sw_rst_req;
            sw_d    = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs decode the next state so they switch on the transition edge.
  assign in_rst = (state_d == S_PRE) || (state_d == S_PRST) ||
                  (state_d == S_RST);

  always_ff @(posedge i_refclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_prst_n      <= 1'b0;
      o_rst         <= 1'b1;
      o_jtag_trst_n <= 1'b0;
      o_clk_en      <= 1'b0;
      o_ready       <= 1'b0;
      o_busy        <= 1'b1;
      o_sw_rst_ack  <= 1'b0;
    end else begin
      o_prst_n      <= (state_d != S_PRE) && (state_d != S_PRST);
      o_rst         <= in_rst;
      o_jtag_trst_n <= !in_rst;
      o_clk_en      <= (state_d == S_SETTLE) || (state_d == S_DONE);
      o_ready       <= (state_d == S_DONE);
      o_busy        <= (state_d != S_DONE);
      o_sw_rst_ack  <= ack_d;
    end
  end

endmodule

// File: tb/tb_wddr_rst_seq.sv
// Directed bench for wddr_rst_seq: default and all-ones parameter sets.
// Vectors are {edge, req to drive after check, expected outputs}.
module tb_wddr_rst_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0, rst_n_m = 1'b0;
  logic req = 1'b0, req_m = 1'b0;

  logic ack, prst_n, rst, trst_n, clk_en, ready, busy;
  logic ack_m, prst_n_m, rst_m, trst_n_m, clk_en_m, ready_m, busy_m;

  always #5 clk = ~clk;

  wddr_rst_seq u_dut (
    .i_refclk      (clk),
    .i_rst_n       (rst_n),
    .i_sw_rst_req  (req),
    .o_sw_rst_ack  (ack),
    .o_prst_n      (prst_n),
    .o_rst         (rst),
    .o_jtag_trst_n (trst_n),
    .o_clk_en      (clk_en),
    .o_ready       (ready),
    .o_busy        (busy)
  );

  wddr_rst_seq #(
    .CNT_W(4), .PRE_CYC(1), .PRST_CYC(1), .RST_CYC(1),
    .CLKEN_CYC(1), .SETTLE_CYC(1)
  ) u_min (
    .i_refclk      (clk),
    .i_rst_n       (rst_n_m),
    .i_sw_rst_req  (req_m),
    .o_sw_rst_ack  (ack_m),
    .o_prst_n      (prst_n_m),
    .o_rst         (rst_m),
    .o_jtag_trst_n (trst_n_m),
    .o_clk_en      (clk_en_m),
    .o_ready       (ready_m),
    .o_busy        (busy_m)
  );

  // {prst_n, rst, trst_n, clk_en, ready, busy, ack}
  localparam logic [6:0] RSTV  = 7'b0100010;
  localparam logic [6:0] SRST  = 7'b1100010;
  localparam logic [6:0] GATE  = 7'b1010010;
  localparam logic [6:0] SETL  = 7'b1011010;
  localparam logic [6:0] DONE  = 7'b1011100;
  localparam logic [6:0] DONEA = 7'b1011101;

  typedef struct {
    int         e;
    logic       r;
    logic [6:0] x;
  } vec_t;

  vec_t tv[$];
  int   ecnt = 0;
  int   n_chk = 0, n_pass = 0;

  always @(posedge clk) ecnt <= ecnt + 1;

  wire [6:0] obs   = {prst_n, rst, trst_n, clk_en, ready, busy, ack};
  wire [6:0] obs_m = {prst_n_m, rst_m, trst_n_m, clk_en_m,
                      ready_m, busy_m, ack_m};

  task automatic chk(string nm, logic [6:0] act, logic [6:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b", nm, act, exp);
  endtask

  task automatic addv(int e, logic r, logic [6:0] x);
    vec_t v;
    v.e = e; v.r = r; v.x = x;
    tv.push_back(v);
  endtask

  task automatic goto(int e);
    while (ecnt < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run(int lo, int hi, int base, bit m, string tag);
    for (int i = lo; i < hi; i++) begin
      goto(base + tv[i].e);
      chk($sformatf("%s@%0d", tag, tv[i].e), m ? obs_m : obs, tv[i].x);
      if (m) req_m = tv[i].r;
      else   req = tv[i].r;
    end
  endtask

  // Ordering invariant on both instances.
  always @(negedge clk) begin
    n_chk++;
    if ((!clk_en || (!rst && prst_n)) && (rst || prst_n)) n_pass++;
    else $display("FAIL order: clk_en=%b rst=%b prst_n=%b",
                  clk_en, rst, prst_n);
    n_chk++;
    if ((!clk_en_m || (!rst_m && prst_n_m)) && (rst_m || prst_n_m))
      n_pass++;
    else $display("FAIL order_min: clk_en=%b rst=%b prst_n=%b",
                  clk_en_m, rst_m, prst_n_m);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  int p_po, p_sw, p_min, p_end, base, base2, bm;

  initial begin
    // power-on, defaults
    addv(0, 0, RSTV);  addv(1, 0, RSTV);  addv(2, 0, RSTV);
    addv(6, 0, RSTV);  addv(7, 0, SRST);  addv(11, 0, SRST);
    addv(12, 0, GATE); addv(16, 0, GATE); addv(17, 0, SETL);
    addv(26, 0, SETL); addv(27, 0, DONE);
    p_po = tv.size();
    // software sequences
    addv(39, 1, DONE);  addv(40, 1, RSTV);  addv(44, 1, RSTV);
    addv(45, 1, SRST);  addv(50, 1, GATE);  addv(55, 1, SETL);
    addv(64, 1, SETL);  addv(65, 1, DONEA); addv(69, 1, DONEA);
    addv(70, 0, DONEA); addv(71, 0, DONE);  addv(75, 1, DONE);
    addv(76, 1, RSTV);  addv(101, 1, DONEA); addv(110, 0, DONEA);
    addv(111, 0, DONE); addv(115, 1, DONE); addv(116, 1, RSTV);
    addv(141, 0, DONEA); addv(142, 0, DONE); addv(150, 1, DONE);
    addv(151, 1, RSTV); addv(155, 0, RSTV); addv(156, 0, SRST);
    addv(176, 0, DONE); addv(180, 0, DONE);
    p_sw = tv.size();
    // all durations = 1
    addv(0, 0, RSTV);  addv(1, 0, RSTV);  addv(2, 0, SRST);
    addv(3, 0, GATE);  addv(4, 0, SETL);  addv(5, 1, DONE);
    addv(6, 0, RSTV);  addv(7, 0, SRST);  addv(10, 0, DONE);
    addv(11, 0, DONE); addv(12, 1, DONE); addv(13, 1, RSTV);
    addv(17, 0, DONEA); addv(18, 0, DONE);
    p_min = tv.size();
    p_end = p_min;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", obs, RSTV);
    rst_n = 1'b1;
    base = ecnt;
    run(0, p_po, base, 1'b0, "por");
    run(p_po, p_sw, base, 1'b0, "sw");

    // reset pulse while in S_RST
    req = 1'b1;
    goto(base + 187);
    chk("pre_pulse", obs, SRST);
    req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", obs, RSTV);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held", obs, RSTV);
    rst_n = 1'b1;
    base2 = ecnt;
    run(0, p_po, base2, 1'b0, "repor");

    @(posedge clk);
    #1;
    rst_n_m = 1'b1;
    bm = ecnt;
    run(p_sw, p_end, bm, 1'b1, "min");

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
